// File: rtl/pc_sequencer.sv
// Program-counter sequencer: computes the next fetch address from a 3-bit mode,
// keeps a small circular return-address stack for JAL/RET and flags rejected
// targets (misaligned) and reserved modes (illegal) as one-cycle pulses.
module pc_sequencer #(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     IMM_W     = 22,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int unsigned     RAS_DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic [2:0]       func,
   input  logic [IMM_W-1:0] imm,
   input  logic [XLEN-1:0]  rs1,
   input  logic             branch_taken,
   output logic [XLEN-1:0]  pcout,
   output logic [XLEN-1:0]  pc_next,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             misaligned,
   output logic             illegal
);

   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   localparam logic [2:0] F_SEQ    = 3'b000;
   localparam logic [2:0] F_BRANCH = 3'b001;
   localparam logic [2:0] F_JAL    = 3'b010;
   localparam logic [2:0] F_JALR   = 3'b011;
   localparam logic [2:0] F_RET    = 3'b100;
   localparam logic [2:0] F_AUIPC  = 3'b101;

   logic [XLEN-1:0]  ras [RAS_DEPTH];
   logic [PTR_W-1:0] top;
   logic [CNT_W-1:0] count;

   logic [XLEN-1:0]  simm;
   logic [XLEN-1:0]  pc_plus4;
   logic [XLEN-1:0]  target;
   logic             do_push;
   logic             do_pop;
   logic             bad_func;
   logic             bad_target;
   logic             accept;

   assign ras_empty = (count == '0);
   assign ras_full  = (count == CNT_W'(RAS_DEPTH));

   // Decode the mode into a target address and the RAS action it requests.
   always_comb begin
      simm     = XLEN'($signed(imm));
      pc_plus4 = pcout + XLEN'(4);
      target   = pc_plus4;
      do_push  = 1'b0;
      do_pop   = 1'b0;
      bad_func = 1'b0;
      case (func)
         F_SEQ:    target = pc_plus4;
         F_BRANCH: target = branch_taken ? (pcout + simm) : pc_plus4;
         F_JAL: begin
            target  = pcout + simm;
            do_push = 1'b1;
         end
         F_JALR:   target = (rs1 + simm) & ~XLEN'(1);
         F_RET: begin
            if (!ras_empty) begin
               target = ras[top];
               do_pop = 1'b1;
            end else begin
               target = rs1 & ~XLEN'(1);
            end
         end
         F_AUIPC:  target = pcout + (simm << 12);
         default:  bad_func = 1'b1;
      endcase
      bad_target = (target[1:0] != 2'b00);
      accept     = !stall && !bad_target;
      if (!reset)
         pc_next = RESET_VEC;
      else if (accept)
         pc_next = target;
      else
         pc_next = pcout;
   end

   // PC, stack pointer/count and fault pulses; a rejected target leaves the RAS alone.
   always_ff @(posedge clock) begin
      if (!reset) begin
         pcout      <= RESET_VEC;
         top        <= '0;
         count      <= '0;
         misaligned <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         pcout      <= pc_next;
         misaligned <= !stall && bad_target;
         illegal    <= !stall && bad_func;
         if (accept && do_push) begin
            // When full, top+1 is the oldest slot, so the push overwrites it.
            top <= top + PTR_W'(1);
            if (!ras_full)
               count <= count + CNT_W'(1);
         end else if (accept && do_pop) begin
            top   <= top - PTR_W'(1);
            count <= count - CNT_W'(1);
         end
      end
   end

   // Stack storage; contents need no reset since the count gates every read.
   always_ff @(posedge clock) begin
      if (reset && accept && do_push)
         ras[top + PTR_W'(1)] <= pc_plus4;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a behavioural model pushes expected
// PC/pc_next/flag values into a scoreboard as stimulus is driven; each test
// task pops and compares after the clock edge.
module tb_pc_sequencer;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned IMM_W = 22;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RVEC  = 32'h0;

   localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, JAL = 3'd2, JALR = 3'd3,
                          RET = 3'd4, AUIPC = 3'd5;

   typedef struct {
      logic        rst;
      logic        stl;
      logic [2:0]  fn;
      logic [21:0] im;
      logic [31:0] r1;
      logic        bt;
   } stim_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] nxt;
      logic [3:0]  flags;
   } exp_t;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             stall = 1'b0;
   logic [2:0]       func = '0;
   logic [IMM_W-1:0] imm = '0;
   logic [XLEN-1:0]  rs1 = '0;
   logic             branch_taken = 1'b0;
   logic [XLEN-1:0]  pcout;
   logic [XLEN-1:0]  pc_next;
   logic             ras_empty;
   logic             ras_full;
   logic             misaligned;
   logic             illegal;

   int unsigned checks = 0;
   int unsigned passed = 0;

   exp_t        exp_q[$];
   logic [31:0] nxt_seen;
   logic [31:0] m_pc = RVEC;
   logic [31:0] m_ras[$];
   logic        m_mis = 1'b0;
   logic        m_ill = 1'b0;

   pc_sequencer #(
      .XLEN(XLEN),
      .IMM_W(IMM_W),
      .RESET_VEC(RVEC),
      .RAS_DEPTH(DEPTH)
   ) dut (
      .clock(clock),
      .reset(reset),
      .stall(stall),
      .func(func),
      .imm(imm),
      .rs1(rs1),
      .branch_taken(branch_taken),
      .pcout(pcout),
      .pc_next(pc_next),
      .ras_empty(ras_empty),
      .ras_full(ras_full),
      .misaligned(misaligned),
      .illegal(illegal)
   );

   always #5 clock = ~clock;

   function automatic stim_t mk(input logic rst, input logic stl, input logic [2:0] fn,
                                input logic [21:0] im, input logic [31:0] r1,
                                input logic bt);
      stim_t s;
      s.rst = rst; s.stl = stl; s.fn = fn; s.im = im; s.r1 = r1; s.bt = bt;
      return s;
   endfunction

   // Drive one cycle, advance the model, push expectations, sample pc_next pre-edge.
   task automatic step(input stim_t s);
      exp_t        e;
      logic [31:0] simm;
      logic [31:0] t;
      logic        push;
      logic        pop;
      reset = s.rst; stall = s.stl; func = s.fn; imm = s.im; rs1 = s.r1;
      branch_taken = s.bt;
      simm = {{10{s.im[21]}}, s.im};
      push = 1'b0;
      pop  = 1'b0;
      t    = m_pc + 32'd4;
      if (!s.rst) begin
         m_pc = RVEC;
         m_ras.delete();
         m_mis = 1'b0;
         m_ill = 1'b0;
         e.nxt = RVEC;
      end else if (s.stl) begin
         m_mis = 1'b0;
         m_ill = 1'b0;
         e.nxt = m_pc;
      end else begin
         case (s.fn)
            BR:    if (s.bt) t = m_pc + simm;
            JAL:   begin t = m_pc + simm; push = 1'b1; end
            JALR:  t = (s.r1 + simm) & 32'hFFFF_FFFE;
            RET:   if (m_ras.size() > 0) begin t = m_ras[$]; pop = 1'b1; end
                   else t = s.r1 & 32'hFFFF_FFFE;
            AUIPC: t = m_pc + (simm << 12);
            default: ;
         endcase
         m_ill = (s.fn >= 3'd6);
         m_mis = (t[1:0] != 2'b00);
         if (m_mis) begin
            e.nxt = m_pc;
         end else begin
            if (push) begin
               if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
               m_ras.push_back(m_pc + 32'd4);
            end
            if (pop) void'(m_ras.pop_back());
            m_pc  = t;
            e.nxt = t;
         end
      end
      e.pc    = m_pc;
      e.flags = {m_ras.size() == 0, m_ras.size() == DEPTH, m_mis, m_ill};
      exp_q.push_back(e);
      #1 nxt_seen = pc_next;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(0, 0, SEQ, 0, 0, 0));
      tbl.push_back(mk(0, 0, SEQ, 0, 0, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, SEQ, 0, 0, 0));
      foreach (tbl[i]) begin
         step(tbl[i]);
         e = exp_q.pop_front();
         checks++;
         if (pcout !== e.pc) $display("FAIL reset[%0d] pcout got %h exp %h", i, pcout, e.pc);
         else passed++;
         checks++;
         if (nxt_seen !== e.nxt) $display("FAIL reset[%0d] pc_next got %h exp %h", i, nxt_seen, e.nxt);
         else passed++;
         checks++;
         if ({ras_empty, ras_full, misaligned, illegal} !== e.flags)
            $display("FAIL reset[%0d] flags got %b exp %b", i, {ras_empty, ras_full, misaligned, illegal}, e.flags);
         else passed++;
      end
   endtask

   task automatic test_branch();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(1, 0, SEQ, 0, 0, 0));            // 0x0C -> 0x10
      tbl.push_back(mk(1, 0, BR, 22'h3FFFF8, 0, 1));    // taken, -8 -> 0x08
      tbl.push_back(mk(1, 0, BR, 22'h3FFFF8, 0, 0));    // not taken -> 0x0C
      tbl.push_back(mk(1, 1, BR, 22'h3FFFF8, 0, 1));    // stalled
      tbl.push_back(mk(1, 1, JAL, 22'h40, 0, 0));       // stalled, no push
      foreach (tbl[i]) begin
         step(tbl[i]);
         e = exp_q.pop_front();
         checks++;
         if (pcout !== e.pc) $display("FAIL branch[%0d] pcout got %h exp %h", i, pcout, e.pc);
         else passed++;
         checks++;
         if (nxt_seen !== e.nxt) $display("FAIL branch[%0d] pc_next got %h exp %h", i, nxt_seen, e.nxt);
         else passed++;
         checks++;
         if ({ras_empty, ras_full, misaligned, illegal} !== e.flags)
            $display("FAIL branch[%0d] flags got %b exp %b", i, {ras_empty, ras_full, misaligned, illegal}, e.flags);
         else passed++;
      end
   endtask

   task automatic test_jal_ret();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(1, 0, JALR, 0, 32'h20, 0));      // pc = 0x20
      tbl.push_back(mk(1, 0, JAL, 22'h100, 0, 0));      // -> 0x120, push 0x24
      tbl.push_back(mk(1, 0, RET, 0, 32'h999, 0));      // -> 0x24
      foreach (tbl[i]) begin
         step(tbl[i]);
         e = exp_q.pop_front();
         checks++;
         if (pcout !== e.pc) $display("FAIL jal_ret[%0d] pcout got %h exp %h", i, pcout, e.pc);
         else passed++;
         checks++;
         if ({ras_empty, ras_full, misaligned, illegal} !== e.flags)
            $display("FAIL jal_ret[%0d] flags got %b exp %b", i, {ras_empty, ras_full, misaligned, illegal}, e.flags);
         else passed++;
      end
   endtask

   task automatic test_ras_full();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(0, 0, SEQ, 0, 0, 0));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, JAL, 22'h40, 0, 0));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, RET, 0, 32'h301, 0));
      foreach (tbl[i]) begin
         step(tbl[i]);
         e = exp_q.pop_front();
         checks++;
         if (pcout !== e.pc) $display("FAIL ras_full[%0d] pcout got %h exp %h", i, pcout, e.pc);
         else passed++;
         checks++;
         if ({ras_empty, ras_full, misaligned, illegal} !== e.flags)
            $display("FAIL ras_full[%0d] flags got %b exp %b", i, {ras_empty, ras_full, misaligned, illegal}, e.flags);
         else passed++;
      end
   endtask

   task automatic test_faults();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(1, 0, JAL, 22'h10, 0, 0));        // put one entry on the RAS
      tbl.push_back(mk(1, 0, JALR, 22'h2, 32'h1001, 0)); // 0x1002: misaligned
      tbl.push_back(mk(1, 0, SEQ, 0, 0, 0));             // pulse clears
      tbl.push_back(mk(1, 0, JAL, 22'h2, 0, 0));         // misaligned JAL: no push
      tbl.push_back(mk(1, 1, SEQ, 0, 0, 0));             // stall clears pulse
      tbl.push_back(mk(1, 0, 3'b111, 0, 0, 0));          // illegal
      tbl.push_back(mk(1, 0, SEQ, 0, 0, 0));
      tbl.push_back(mk(1, 0, 3'b110, 0, 0, 0));
      tbl.push_back(mk(1, 1, 3'b110, 0, 0, 0));          // stalled reserved func
      foreach (tbl[i]) begin
         step(tbl[i]);
         e = exp_q.pop_front();
         checks++;
         if (pcout !== e.pc) $display("FAIL faults[%0d] pcout got %h exp %h", i, pcout, e.pc);
         else passed++;
         checks++;
         if (nxt_seen !== e.nxt) $display("FAIL faults[%0d] pc_next got %h exp %h", i, nxt_seen, e.nxt);
         else passed++;
         checks++;
         if ({ras_empty, ras_full, misaligned, illegal} !== e.flags)
            $display("FAIL faults[%0d] flags got %b exp %b", i, {ras_empty, ras_full, misaligned, illegal}, e.flags);
         else passed++;
      end
   endtask

   task automatic test_wrap();
      stim_t tbl[$];
      exp_t  e;
      tbl.push_back(mk(1, 0, JALR, 0, 32'hFFFF_FFFC, 0));
      tbl.push_back(mk(1, 0, SEQ, 0, 0, 0));             // wraps to 0
      tbl.push_back(mk(1, 0, AUIPC, 22'h1, 0, 0));       // -> 0x1000
      tbl.push_back(mk(1, 0, JAL, 22'h8, 0, 0));
      tbl.push_back(mk(1, 0, JAL, 22'h8, 0, 0));
      tbl.push_back(mk(0, 1, JAL, 22'h8, 0, 0));         // reset beats stall
      tbl.push_back(mk(1, 0, RET, 0, 32'h55, 0));        // stale entries unreachable
      foreach (tbl[i]) begin
         step(tbl[i]);
         e = exp_q.pop_front();
         checks++;
         if (pcout !== e.pc) $display("FAIL wrap[%0d] pcout got %h exp %h", i, pcout, e.pc);
         else passed++;
         checks++;
         if ({ras_empty, ras_full, misaligned, illegal} !== e.flags)
            $display("FAIL wrap[%0d] flags got %b exp %b", i, {ras_empty, ras_full, misaligned, illegal}, e.flags);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      stim_t       s;
      logic [21:0] im;
      for (int i = 0; i < 300; i++) begin
         im = 22'($urandom_range(0, 255)) << 2;
         if ($urandom_range(0, 1) == 1) im = -im;
         if ($urandom_range(0, 9) == 0) im = im | 22'($urandom_range(1, 3));
         s = mk($urandom_range(0, 39) != 0, $urandom_range(0, 5) == 0,
                3'($urandom_range(0, 7)), im, $urandom, 1'($urandom_range(0, 1)));
         step(s);
         e = exp_q.pop_front();
         checks++;
         if (pcout !== e.pc) $display("FAIL b2b[%0d] pcout got %h exp %h", i, pcout, e.pc);
         else passed++;
         checks++;
         if (nxt_seen !== e.nxt) $display("FAIL b2b[%0d] pc_next got %h exp %h", i, nxt_seen, e.nxt);
         else passed++;
         checks++;
         if ({ras_empty, ras_full, misaligned, illegal} !== e.flags)
            $display("FAIL b2b[%0d] flags got %b exp %b", i, {ras_empty, ras_full, misaligned, illegal}, e.flags);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_jal_ret();
      test_ras_full();
      test_faults();
      test_wrap();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
